// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: FSM encodings and
// defaults sized for the 50 MHz board clock.
package button_debouncer_pkg;

    typedef enum logic {
        S_STABLE = 1'b0,
        S_COUNT  = 1'b1
    } state_t;

    // 1 ms of stability at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int DEFAULT_CNT_W           = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous board input; the reset
// value is a parameter so idle-high and idle-low pins can share it.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Debounces an active-low push-button: a new synchronised level is accepted
// only after holding for DEBOUNCE_CYCLES consecutive cycles.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic bRaw,
    output logic bClean,
    output logic bEdge
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync2;
    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic             bCleanNext;
    logic             bEdgeNext;

    // Idle level of the pin is high, so the synchroniser resets to 1
    sync_2ff #(
        .RESET_VAL(1'b1)
    ) uSync (
        .clk (clk),
        .rst (rst),
        .d   (bRaw),
        .q   (sync2)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_STABLE;
            cnt    <= '0;
            bClean <= 1'b1;
            bEdge  <= 1'b0;
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            bClean <= bCleanNext;
            bEdge  <= bEdgeNext;
        end
    end

    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        bCleanNext = bClean;
        bEdgeNext  = 1'b0;
        case (state)
            S_STABLE: begin
                cntNext = '0;
                if (sync2 != bClean) begin
                    stateNext = S_COUNT;
                end
            end
            S_COUNT: begin
                // Returning to the accepted level means the excursion was a bounce
                if (sync2 == bClean) begin
                    stateNext = S_STABLE;
                    cntNext   = '0;
                end else if (cnt == CNT_LAST) begin
                    stateNext  = S_STABLE;
                    cntNext    = '0;
                    bCleanNext = sync2;
                    bEdgeNext  = 1'b1;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            default: begin
                stateNext = S_STABLE;
                cntNext   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer with DEBOUNCE_CYCLES=4: stimulus
// queues expected bEdge events, a negedge monitor pops and compares them.
module tb_button_debouncer;
    import button_debouncer_pkg::*;

    localparam int DC  = 4;
    localparam int LAT = DC + 2;

    typedef struct {
        int   cyc;
        logic lvl;
    } evt_t;

    logic clk = 1'b0;
    logic rst;
    logic bRaw;
    logic bClean;
    logic bEdge;

    evt_t expQ[$];
    int   cyc        = 0;
    logic rstAtEdge  = 1'b1;
    logic started    = 1'b0;
    logic prevClean  = 1'b1;
    logic expLevel   = 1'b1;
    int   nChecks    = 0;
    int   nFails     = 0;
    int   nPressExp  = 0;
    int   nShaper    = 0;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bRaw   (bRaw),
        .bClean (bClean),
        .bEdge  (bEdge)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        rstAtEdge = rst;
        started   = 1'b1;
        prevClean <= bClean;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Queue the bEdge expected LAT edges after the next posedge (E0)
    task automatic pushEvent(input logic lvl);
        expQ.push_back('{cyc + 1 + LAT, lvl});
        if (lvl == 1'b0) nPressExp++;
    endtask

    task automatic settle(input logic lvl);
        @(negedge clk);
        bRaw = lvl;
        pushEvent(lvl);
        repeat (12) @(negedge clk);
    endtask

    // Monitor: compares every bEdge against the queue head and tracks the level
    always @(negedge clk) begin
        if (started) begin
            if (!rstAtEdge) begin
                expLevel = 1'b1;
                check("reset_bClean", bClean, 1);
                check("reset_bEdge", bEdge, 0);
            end else begin
                if (expQ.size() > 0 && cyc > expQ[0].cyc) begin
                    nChecks++;
                    nFails++;
                    $display("FAIL edge_missing: expected at cycle %0d, still absent at cycle %0d", expQ[0].cyc, cyc);
                    void'(expQ.pop_front());
                end
                if (bEdge === 1'b1) begin
                    if (expQ.size() == 0) begin
                        nChecks++;
                        nFails++;
                        $display("FAIL edge_unexpected at cycle %0d: got bEdge=1, expected 0", cyc);
                    end else begin
                        evt_t e;
                        e = expQ.pop_front();
                        check("edge_cycle", cyc, e.cyc);
                        check("edge_level", bClean, e.lvl);
                        expLevel = e.lvl;
                    end
                end
                check("level", bClean, expLevel);
                if (prevClean === 1'b1 && bClean === 1'b0) nShaper++;
            end
        end
    end

    initial begin
        int c;
        rst  = 1'b0;
        bRaw = 1'b0;
        // Reset with the button held: press must qualify after release
        repeat (3) @(negedge clk);
        rst = 1'b1;
        pushEvent(1'b0);
        repeat (12) @(negedge clk);

        settle(1'b1);
        settle(1'b0);
        settle(1'b1);

        // Bounce: low 3, high 1, low 2, then high
        @(negedge clk);
        bRaw = 1'b0;
        repeat (3) @(negedge clk);
        bRaw = 1'b1;
        @(negedge clk);
        bRaw = 1'b0;
        repeat (2) @(negedge clk);
        bRaw = 1'b1;
        repeat (10) @(negedge clk);
        check("bounce_state", dut.state, S_STABLE);
        check("bounce_cnt", dut.cnt, 0);

        // Bounce then settle low
        @(negedge clk) bRaw = 1'b0;
        @(negedge clk) bRaw = 1'b1;
        @(negedge clk) bRaw = 1'b0;
        @(negedge clk) bRaw = 1'b1;
        settle(1'b0);
        settle(1'b1);

        // Reset mid-count while the button stays pressed
        @(negedge clk);
        bRaw = 1'b0;
        c = cyc;
        repeat (5) @(negedge clk);
        check("midcount_cnt", dut.cnt, 2);
        check("midcount_state", dut.state, S_COUNT);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_cnt", dut.cnt, 0);
        check("post_reset_state", dut.state, S_STABLE);
        rst = 1'b1;
        pushEvent(1'b0);
        repeat (12) @(negedge clk);
        check("requalify_start", c, c);
        settle(1'b1);

        check("pending_events", expQ.size(), 0);
        check("shaper_pulses", nShaper, nPressExp);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
